// File: rtl/morse_symbol_sequencer.sv
// Groups dot/dash pulses into Morse letters, ends a letter after an idle gap,
// and hands each completed letter downstream over a valid/ready handshake.
module morse_symbol_sequencer #(
    parameter int MAX_SYMS  = 5,
    parameter int GAP_TICKS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                dot,
    input  logic                dash,
    input  logic                out_ready,
    output logic                letter_valid,
    output logic [MAX_SYMS-1:0] letter_bits,
    output logic [2:0]          letter_len,
    output logic                overflow,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    localparam logic [3:0] GAP_LIM = 4'(GAP_TICKS);
    localparam logic [2:0] LEN_MAX = 3'(MAX_SYMS);

    state_t     state_r;
    logic [3:0] gap_r;
    logic       pend_full_r;
    logic       pend_sym_r;

    logic       sym_ev_s;
    logic       sym_s;
    logic [3:0] gap_inc_s;
    logic       gap_done_s;
    logic       handshake_s;

    // Places one symbol at position pos of the accumulated letter.
    function automatic logic [MAX_SYMS-1:0] add_sym(
        input logic [MAX_SYMS-1:0] bits,
        input logic [2:0]          pos,
        input logic                sym
    );
        add_sym = bits | (MAX_SYMS'(sym) << pos);
    endfunction

    // dot and dash together is not a symbol; it behaves as an idle cycle.
    assign sym_ev_s    = dot ^ dash;
    assign sym_s       = dash;
    assign gap_inc_s   = (gap_r == 4'hF) ? gap_r : (gap_r + 4'd1);
    assign gap_done_s  = (gap_inc_s >= GAP_LIM);
    assign handshake_s = letter_valid & out_ready;

    // Letter sequencing FSM with all outputs held in registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            gap_r        <= 4'd0;
            pend_full_r  <= 1'b0;
            pend_sym_r   <= 1'b0;
            letter_valid <= 1'b0;
            letter_bits  <= '0;
            letter_len   <= 3'd0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
        end else if (clear) begin
            state_r      <= ST_IDLE;
            gap_r        <= 4'd0;
            pend_full_r  <= 1'b0;
            pend_sym_r   <= 1'b0;
            letter_valid <= 1'b0;
            letter_bits  <= '0;
            letter_len   <= 3'd0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sym_ev_s) begin
                        letter_bits <= MAX_SYMS'(sym_s);
                        letter_len  <= 3'd1;
                        gap_r       <= 4'd0;
                        state_r     <= ST_COLLECT;
                        busy        <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                ST_COLLECT: begin
                    if (sym_ev_s) begin
                        gap_r <= 4'd0;
                        if (letter_len < LEN_MAX) begin
                            letter_bits <= add_sym(letter_bits, letter_len, sym_s);
                            letter_len  <= letter_len + 3'd1;
                        end else begin
                            overflow    <= 1'b1;
                            letter_bits <= '0;
                            letter_len  <= 3'd0;
                            state_r     <= ST_DROP;
                        end
                    end else if (gap_done_s) begin
                        gap_r        <= 4'd0;
                        letter_valid <= 1'b1;
                        state_r      <= ST_EMIT;
                    end else begin
                        gap_r <= gap_inc_s;
                    end
                end

                ST_EMIT: begin
                    if (handshake_s) begin
                        letter_valid <= 1'b0;
                        gap_r        <= 4'd0;
                        if (pend_full_r) begin
                            // Older pending symbol wins; a new one this cycle is lost.
                            letter_bits <= MAX_SYMS'(pend_sym_r);
                            letter_len  <= 3'd1;
                            pend_full_r <= 1'b0;
                            pend_sym_r  <= 1'b0;
                            state_r     <= ST_COLLECT;
                            if (sym_ev_s) begin
                                overflow <= 1'b1;
                            end else begin
                                overflow <= overflow;
                            end
                        end else if (sym_ev_s) begin
                            letter_bits <= MAX_SYMS'(sym_s);
                            letter_len  <= 3'd1;
                            state_r     <= ST_COLLECT;
                        end else begin
                            letter_bits <= '0;
                            letter_len  <= 3'd0;
                            state_r     <= ST_IDLE;
                            busy        <= 1'b0;
                        end
                    end else if (sym_ev_s) begin
                        if (pend_full_r) begin
                            overflow <= 1'b1;
                        end else begin
                            pend_full_r <= 1'b1;
                            pend_sym_r  <= sym_s;
                        end
                    end else begin
                        letter_valid <= 1'b1;
                    end
                end

                ST_DROP: begin
                    if (sym_ev_s) begin
                        gap_r <= 4'd0;
                    end else if (gap_done_s) begin
                        gap_r   <= 4'd0;
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        gap_r <= gap_inc_s;
                    end
                end

                default: begin
                    state_r      <= ST_IDLE;
                    gap_r        <= 4'd0;
                    pend_full_r  <= 1'b0;
                    letter_valid <= 1'b0;
                    letter_bits  <= '0;
                    letter_len   <= 3'd0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule
